mfd_data_lba_gen: RTL and testbench

//   Command-to-sector address expander; stage directly upstream of mfd_data_lba.

---
 rtl/mfd_data_lba_gen.sv | 165 ++++++++++++++++
 tb/tb_mfd_data_lba_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfd_data_lba_gen.sv
// -----------------------------------------------------------------------------
// mfd_data_lba_gen
//   Command-to-sector address expander. Takes one command (start LBA plus
//   sector count) and emits one LBA per sector on a valid/ready stream that
//   mfd_data_lba consumes. A command can be aborted mid-stream, and completion
//   is signalled with a one-cycle done pulse.
//
//   Optional feature macro: MFD_LBA_RANGE_CHECK_EN
//     When defined, a command whose last sector would pass MAX_LBA is rejected
//     at acceptance. It emits no beats and raises err together with done.
//     When undefined, err is tied low and the LBA wraps modulo 2^LBA_W.
//
// Parameters
//   LBA_W    width of logical block address
//   CNT_W    width of sector count
//   MAX_LBA  highest legal LBA (only consulted with MFD_LBA_RANGE_CHECK_EN)
//
// Ports
//   clk        single clock, all logic rising-edge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command offered
//   cmd_ready  block can accept a command (combinational, high in IDLE)
//   cmd_lba    start LBA
//   cmd_cnt    sector count (0 = no-op command)
//   abort      terminate current command (only honoured while running)
//   lba_valid  lba_out valid toward mfd_data_lba
//   lba_ready  downstream accepts
//   lba_out    current sector LBA
//   lba_last   current beat is the final sector of the command
//   busy       block is not idle (combinational)
//   done       one-cycle pulse at command completion
//   err        one-cycle range-error pulse, coincident with done
// -----------------------------------------------------------------------------
module mfd_data_lba_gen #(
  parameter int              LBA_W   = 48,
  parameter int              CNT_W   = 16,
  parameter logic [LBA_W-1:0] MAX_LBA = {LBA_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LBA_W-1:0] cmd_lba,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             abort,
  output logic             lba_valid,
  input  logic             lba_ready,
  output logic [LBA_W-1:0] lba_out,
  output logic             lba_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             xfer;
  logic             range_bad;

  assign xfer = lba_valid & lba_ready;

`ifdef MFD_LBA_RANGE_CHECK_EN
  // One extra bit so a command running past the top of the address space
  // shows up as a large end address rather than silently wrapping.
  logic [LBA_W:0] end_lba;

  assign end_lba   = {1'b0, cmd_lba} + (LBA_W+1)'(cmd_cnt) - (LBA_W+1)'(1);
  assign range_bad = (cmd_cnt != '0) && (end_lba > {1'b0, MAX_LBA});
`else
  assign range_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A zero-length or out-of-range command goes straight to
  // DONE so it still produces exactly one done pulse.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = ((cmd_cnt == '0) || range_bad) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort || (xfer && (remaining == CNT_W'(1)))) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Registered outputs and datapath. done/err are raised on entry to DONE, so
  // they are high exactly during the single DONE cycle. lba_last looks one
  // beat ahead: after a transfer with two sectors left, the next beat is last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lba_valid <= 1'b0;
      lba_out   <= '0;
      lba_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            lba_out   <= cmd_lba;
            remaining <= cmd_cnt;
            if (state_nxt == DONE) begin
              lba_valid <= 1'b0;
              lba_last  <= 1'b0;
              done      <= 1'b1;
              err       <= range_bad;
            end else begin
              lba_valid <= 1'b1;
              lba_last  <= (cmd_cnt == CNT_W'(1));
            end
          end
        end
        RUN: begin
          if (state_nxt == DONE) begin
            lba_valid <= 1'b0;
            lba_last  <= 1'b0;
            done      <= 1'b1;
            if (xfer) begin
              remaining <= remaining - CNT_W'(1);
            end
          end else if (xfer) begin
            lba_out   <= lba_out + LBA_W'(1);
            remaining <= remaining - CNT_W'(1);
            lba_last  <= (remaining == CNT_W'(2));
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfd_data_lba_gen.sv
// -----------------------------------------------------------------------------
// tb_mfd_data_lba_gen
//   Scoreboard bench for mfd_data_lba_gen. Each issued command pushes the beats
//   it should produce, plus one completion record, into queues. A negedge
//   monitor pops and compares them whenever the DUT transfers a beat or
//   pulses done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mfd_data_lba_gen;

  localparam int LBA_W = 48;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LBA_W-1:0] cmd_lba;
  logic [CNT_W-1:0] cmd_cnt;
  logic             abort;
  logic             lba_valid;
  logic             lba_ready;
  logic [LBA_W-1:0] lba_out;
  logic             lba_last;
  logic             busy;
  logic             done;
  logic             err;

  mfd_data_lba_gen #(.LBA_W(LBA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_lba   (cmd_lba),
    .cmd_cnt   (cmd_cnt),
    .abort     (abort),
    .lba_valid (lba_valid),
    .lba_ready (lba_ready),
    .lba_out   (lba_out),
    .lba_last  (lba_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LBA_W-1:0] lba;
    logic             last;
  } beat_t;

  typedef struct {
    int   beats;
    logic err;
  } cmpl_t;

  beat_t beatQ[$];
  cmpl_t doneQ[$];
  int    errors = 0;
  int    checks = 0;
  int    beatsSeen = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=event expected=none at %0t", name, $time);
  endtask

  // Reference model: a command delivers sectors lba, lba+1, ... (mod 2^48).
  // An abort on transfer k truncates it to k beats. lba_last marks only the
  // true final sector of the command.
  task automatic pushExpected(input logic [LBA_W-1:0] lba, input int cnt, input int abortAt);
    int    n;
    logic  e;
    beat_t b;
    n = cnt;
    e = 1'b0;
`ifdef MFD_LBA_RANGE_CHECK_EN
    begin
      logic [LBA_W:0] endv;
      endv = {1'b0, lba} + (LBA_W+1)'(cnt) - (LBA_W+1)'(1);
      if (cnt != 0 && endv[LBA_W]) begin
        n = 0;
        e = 1'b1;
      end
    end
`endif
    if (abortAt > 0 && abortAt < n) n = abortAt;
    for (int i = 0; i < n; i++) begin
      b.lba  = lba + LBA_W'(i);
      b.last = (i == cnt - 1);
      beatQ.push_back(b);
    end
    doneQ.push_back('{beats: n, err: e});
  endtask

  // Issue one command and drive lba_ready until the block is idle again.
  // abortAt>0 asserts abort together with that transfer number.
  // readyPct is used once the pattern (patLen bits) has been exhausted.
  task automatic applyStimulus(input logic [LBA_W-1:0] lba, input int cnt, input int abortAt,
                               input int readyPct, input logic [7:0] pat, input int patLen);
    int   guard;
    int   xfers;
    int   idx;
    logic willX;
    pushExpected(lba, cnt, abortAt);
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("cmdReadyBeforeIssue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_lba   = lba;
    cmd_cnt   = CNT_W'(cnt);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("cmdReadyLowAfterAccept", cmd_ready, 0);
    guard = 0;
    xfers = 0;
    idx   = 0;
    while (!cmd_ready && guard < 400) begin
      if (idx < patLen) lba_ready = pat[idx];
      else if (readyPct >= 100) lba_ready = 1'b1;
      else lba_ready = ($urandom_range(99) < readyPct);
      idx++;
      abort = 1'b0;
      if (abortAt > 0 && lba_valid && xfers == abortAt - 1) begin
        lba_ready = 1'b1;
        abort     = 1'b1;
      end
      willX = lba_valid && lba_ready;
      @(posedge clk); #1;
      if (willX) xfers++;
      abort = 1'b0;
      guard++;
    end
    checkOutput("cmdCompleteTimeout", cmd_ready, 1);
  endtask

  // Monitor / scoreboard
  logic             prevStall = 1'b0;
  logic             prevDone  = 1'b0;
  logic [LBA_W-1:0] prevLba   = '0;
  logic             prevLast  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 1'b0;
      prevDone  = 1'b0;
      beatsSeen = 0;
    end else begin
      if (prevStall && lba_valid) begin
        checkOutput("stallHoldLba", 64'(lba_out), 64'(prevLba));
        checkOutput("stallHoldLast", 64'(lba_last), 64'(prevLast));
      end
      if (busy && cmd_ready) failNow("cmdReadyWhileBusy");
      if (lba_valid && lba_ready) begin
        if (beatQ.size() == 0) begin
          failNow("unexpectedBeat");
        end else begin
          beat_t b;
          b = beatQ.pop_front();
          checkOutput("beatLba", 64'(lba_out), 64'(b.lba));
          checkOutput("beatLast", 64'(lba_last), 64'(b.last));
        end
        beatsSeen++;
      end
      if (done) begin
        if (prevDone) failNow("donePulseWidth");
        if (doneQ.size() == 0) begin
          failNow("unexpectedDone");
        end else begin
          cmpl_t c;
          c = doneQ.pop_front();
          checkOutput("beatCount", 64'(beatsSeen), 64'(c.beats));
          checkOutput("errFlag", 64'(err), 64'(c.err));
        end
        beatsSeen = 0;
      end else if (err) begin
        failNow("errWithoutDone");
      end
      prevStall = lba_valid && !lba_ready;
      prevLba   = lba_out;
      prevLast  = lba_last;
      prevDone  = done;
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmdReady"}, 64'(cmd_ready), 1);
    checkOutput({tag, "_lbaValid"}, 64'(lba_valid), 0);
    checkOutput({tag, "_lbaOut"}, 64'(lba_out), 0);
    checkOutput({tag, "_lbaLast"}, 64'(lba_last), 0);
    checkOutput({tag, "_busy"}, 64'(busy), 0);
    checkOutput({tag, "_done"}, 64'(done), 0);
    checkOutput({tag, "_err"}, 64'(err), 0);
  endtask

  // Hard time limit so a stuck DUT still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_lba   = '0;
    cmd_cnt   = '0;
    abort     = 1'b0;
    lba_ready = 1'b0;
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain 4-sector command with downstream always ready
    applyStimulus(48'h100, 4, 0, 100, 8'h00, 0);
    // Stalls: ready 1,0,0,1,1
    applyStimulus(48'h2000, 3, 0, 100, 8'b0001_1001, 5);
    // Zero-length command
    applyStimulus(48'h5555, 0, 0, 100, 8'h00, 0);
    // Abort coinciding with the second transfer
    applyStimulus(48'hABC000, 10, 2, 100, 8'h00, 0);
    // Top of address space (wraps, or is rejected with the range check)
    applyStimulus(48'hFFFF_FFFF_FFFF, 2, 0, 100, 8'h00, 0);
    // Single-sector command
    applyStimulus(48'h7, 1, 0, 100, 8'h00, 0);

    // Reset in the middle of a command, while the second beat is presented
    pushExpected(48'h9000, 10, 0);
    cmd_valid = 1'b1;
    cmd_lba   = 48'h9000;
    cmd_cnt   = 16'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lba_ready = 1'b1;
    @(posedge clk); #1;
    lba_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midReset");
    beatQ.delete();
    doneQ.delete();
    beatsSeen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(48'h4242, 3, 0, 100, 8'h00, 0);

    // Randomised commands
    for (int n = 0; n < 40; n++) begin
      logic [LBA_W-1:0] l;
      int               c;
      int               a;
      l = {16'($urandom()), $urandom()};
      if ($urandom_range(3) == 0) l = 48'hFFFF_FFFF_FFFF - LBA_W'($urandom_range(8));
      c = $urandom_range(12);
      a = ($urandom_range(3) == 0) ? $urandom_range(6, 1) : 0;
      applyStimulus(l, c, a, 60, 8'h00, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("beatQueueEmpty", 64'(beatQ.size()), 0);
    checkOutput("doneQueueEmpty", 64'(doneQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
